// File: rtl/ir_consts.sv
// Shared constants for the IR transmitter path: datapath width and carrier/bit
// timing terminal counts for the frequency generators.
package ir_consts;

  localparam int INT_SIZE = 32;

  typedef logic [INT_SIZE-1:0] count_t;

  localparam longint unsigned SYS_CLK_HZ = 64'd50_000_000;
  localparam longint unsigned CARRIER_HZ = 64'd38_000;
  localparam longint unsigned BIT_TICK_HZ = 64'd1_778;

  // Terminal value M such that one pulse occurs every sys_hz/tick_hz cycles.
  function automatic count_t tick_terminal(input longint unsigned sys_hz,
                                           input longint unsigned tick_hz);
    return count_t'((sys_hz / tick_hz) - 64'd1);
  endfunction

  // Carrier needs out_clk at CARRIER_HZ, so the wrap rate is twice that.
  localparam count_t CARRIER_TERMINAL = tick_terminal(SYS_CLK_HZ, 2 * CARRIER_HZ);
  localparam count_t BIT_TERMINAL     = tick_terminal(SYS_CLK_HZ, BIT_TICK_HZ);

endpackage

// File: rtl/frequency_generator_if.sv
// Terminal-count input and divided outputs of a frequency generator.
interface frequency_generator_if;
  import ir_consts::*;

  count_t max_counter_value;
  logic   out_clk;
  logic   out_pulse;

  modport master (
    output max_counter_value,
    input  out_clk,
    input  out_pulse
  );

  modport slave (
    input  max_counter_value,
    output out_clk,
    output out_pulse
  );

endinterface

// File: rtl/frequency_generator.sv
// Programmable tick generator: a strobe every M+1 sys_clk cycles and a 50%-duty
// clock that toggles on each wrap.
module frequency_generator
  import ir_consts::*;
(
    input logic sys_clk,
    input logic reset,
    frequency_generator_if.slave bus
);

    count_t cnt;
    logic   wrap;
    logic   pulse_q;
    logic   clk_q;

    // The >= compare lets a shrinking M take effect at once without overrunning.
    assign wrap = (cnt >= bus.max_counter_value);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + count_t'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            pulse_q <= 1'b0;
            clk_q   <= 1'b0;
        end else begin
            pulse_q <= wrap;
            if (wrap) begin
                clk_q <= ~clk_q;
            end
        end
    end

    assign bus.out_pulse = pulse_q;
    assign bus.out_clk   = clk_q;

endmodule

// File: tb/tb_frequency_generator.sv
// Self-checking bench for frequency_generator against a period-based reference model.
module tb_frequency_generator;
    import ir_consts::*;

    logic sys_clk = 1'b0;
    logic reset;

    frequency_generator_if bus ();

    frequency_generator dut (
        .sys_clk(sys_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    // Reference: cycles already spent in the current period, pulses emitted so far.
    longint unsigned exp_elapsed;
    longint unsigned exp_pulses;
    logic            exp_pulse;
    logic            exp_clk;

    task automatic model_reset();
        exp_elapsed = 0;
        exp_pulses  = 0;
        exp_pulse   = 1'b0;
        exp_clk     = 1'b0;
    endtask

    // One sys_clk edge; a period ends once it has lasted M+1 edges (M read at the edge).
    task automatic advance();
        longint unsigned period_len;
        @(posedge sys_clk);
        period_len = longint'(bus.max_counter_value) + 64'd1;
        if (exp_elapsed + 64'd1 >= period_len) begin
            exp_elapsed = 0;
            exp_pulses  = exp_pulses + 1;
            exp_pulse   = 1'b1;
        end else begin
            exp_elapsed = exp_elapsed + 1;
            exp_pulse   = 1'b0;
        end
        exp_clk = exp_pulses[0];
        @(negedge sys_clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        model_reset();
        @(negedge sys_clk);
        checks++;
        if (bus.out_clk !== 1'b0 || bus.out_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulse: out_clk=%b out_pulse=%b required 0 0", bus.out_clk, bus.out_pulse);
        end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int first;
        reset = 1'b1;
        bus.max_counter_value = 10;
        model_reset();
        repeat (2) begin
            @(negedge sys_clk);
            checks++;
            if (bus.out_clk !== 1'b0 || bus.out_pulse !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold: out_clk=%b out_pulse=%b required 0 0", bus.out_clk, bus.out_pulse);
            end
        end
        reset = 1'b0;
        first = 0;
        for (int i = 1; i <= 11; i++) begin
            advance();
            checks++;
            if (bus.out_pulse !== exp_pulse || bus.out_clk !== exp_clk) begin
                failures++;
                $display("FAIL reset_release edge %0d: pulse=%b clk=%b required %b %b", i, bus.out_pulse, bus.out_clk, exp_pulse, exp_clk);
            end
            if (bus.out_pulse === 1'b1 && first == 0) first = i;
        end
        checks++;
        if (first != 11 || bus.out_clk !== 1'b1) begin
            failures++;
            $display("FAIL first_pulse: edge=%0d clk=%b required edge 11 clk 1", first, bus.out_clk);
        end
    endtask

    task automatic test_duty();
        int  hi;
        int  lo;
        int  guard;
        logic prev;
        bus.max_counter_value = 10;
        // Find a rising edge of out_clk.
        prev  = bus.out_clk;
        guard = 0;
        do begin
            prev = bus.out_clk;
            advance();
            guard++;
        end while (!(prev === 1'b0 && bus.out_clk === 1'b1) && guard < 40);
        checks++;
        if (guard >= 40) begin
            failures++;
            $display("FAIL duty_rise: no out_clk rise within 40 cycles, got %0d required <40", guard);
        end
        hi = 1;
        guard = 0;
        forever begin
            advance();
            checks++;
            if (bus.out_pulse !== exp_pulse || bus.out_clk !== exp_clk) begin
                failures++;
                $display("FAIL duty_model: pulse=%b clk=%b required %b %b", bus.out_pulse, bus.out_clk, exp_pulse, exp_clk);
            end
            if (bus.out_clk !== 1'b1 || ++guard > 40) break;
            hi++;
        end
        lo = 1;
        guard = 0;
        forever begin
            advance();
            if (bus.out_clk !== 1'b0 || ++guard > 40) break;
            lo++;
        end
        checks++;
        if (hi != 11) begin
            failures++;
            $display("FAIL duty_high: %0d cycles required 11", hi);
        end
        checks++;
        if (lo != 11) begin
            failures++;
            $display("FAIL duty_low: %0d cycles required 11", lo);
        end
    endtask

    task automatic test_sweep();
        int m_list[5] = '{10, 20, 50, 128, 256};
        int nonpulse;
        int pulses;
        foreach (m_list[k]) begin
            bus.max_counter_value = count_t'(m_list[k]);
            pulse_reset();
            nonpulse = 0;
            pulses   = 0;
            repeat (2 * (m_list[k] + 1) + 2) begin
                advance();
                checks++;
                if (bus.out_pulse !== exp_pulse || bus.out_clk !== exp_clk) begin
                    failures++;
                    $display("FAIL sweep_model M=%0d: pulse=%b clk=%b required %b %b", m_list[k], bus.out_pulse, bus.out_clk, exp_pulse, exp_clk);
                end
                if (bus.out_pulse === 1'b1) begin
                    pulses++;
                    checks++;
                    if (nonpulse != m_list[k]) begin
                        failures++;
                        $display("FAIL sweep_gap M=%0d: %0d idle cycles required %0d", m_list[k], nonpulse, m_list[k]);
                    end
                    nonpulse = 0;
                end else begin
                    nonpulse++;
                end
            end
            checks++;
            if (pulses != 2) begin
                failures++;
                $display("FAIL sweep_count M=%0d: %0d pulses required 2", m_list[k], pulses);
            end
        end
    endtask

    task automatic test_m_zero_one();
        logic prev_clk;
        bus.max_counter_value = 0;
        pulse_reset();
        prev_clk = 1'b0;
        repeat (8) begin
            advance();
            checks++;
            if (bus.out_pulse !== 1'b1 || bus.out_clk !== ~prev_clk || bus.out_clk !== exp_clk) begin
                failures++;
                $display("FAIL m_zero: pulse=%b clk=%b required 1 %b", bus.out_pulse, bus.out_clk, ~prev_clk);
            end
            prev_clk = bus.out_clk;
        end
        bus.max_counter_value = 1;
        repeat (8) begin
            advance();
            checks++;
            if (bus.out_pulse !== exp_pulse || bus.out_clk !== exp_clk) begin
                failures++;
                $display("FAIL m_one: pulse=%b clk=%b required %b %b", bus.out_pulse, bus.out_clk, exp_pulse, exp_clk);
            end
        end
    endtask

    task automatic test_reduce();
        int pulse_at[$];
        bus.max_counter_value = 50;
        pulse_reset();
        repeat (30) advance();
        bus.max_counter_value = 5;
        for (int i = 1; i <= 13; i++) begin
            advance();
            checks++;
            if (bus.out_pulse !== exp_pulse || bus.out_clk !== exp_clk) begin
                failures++;
                $display("FAIL reduce_model edge %0d: pulse=%b clk=%b required %b %b", i, bus.out_pulse, bus.out_clk, exp_pulse, exp_clk);
            end
            if (bus.out_pulse === 1'b1) pulse_at.push_back(i);
        end
        checks++;
        if (pulse_at.size() != 3 || pulse_at[0] != 1 || pulse_at[1] != 7 || pulse_at[2] != 13) begin
            failures++;
            $display("FAIL reduce_pulses: %0d pulses first at %0d required 3 at 1,7,13", pulse_at.size(), pulse_at.size() > 0 ? pulse_at[0] : -1);
        end
    endtask

    task automatic test_async_reset();
        int first;
        bus.max_counter_value = 10;
        pulse_reset();
        repeat (15) advance();
        checks++;
        if (bus.out_clk !== 1'b1) begin
            failures++;
            $display("FAIL async_pre: out_clk=%b required 1", bus.out_clk);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.out_clk !== 1'b0 || bus.out_pulse !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: out_clk=%b out_pulse=%b required 0 0", bus.out_clk, bus.out_pulse);
        end
        model_reset();
        @(negedge sys_clk);
        reset = 1'b0;
        first = 0;
        for (int i = 1; i <= 11; i++) begin
            advance();
            if (bus.out_pulse === 1'b1 && first == 0) first = i;
        end
        checks++;
        if (first != 11 || bus.out_clk !== 1'b1) begin
            failures++;
            $display("FAIL async_restart: first pulse edge=%0d clk=%b required 11 1", first, bus.out_clk);
        end
    endtask

    task automatic test_random();
        repeat (400) begin
            if ($urandom_range(0, 9) == 0) bus.max_counter_value = count_t'($urandom_range(0, 20));
            if ($urandom_range(0, 59) == 0) pulse_reset();
            advance();
            checks++;
            if (bus.out_pulse !== exp_pulse || bus.out_clk !== exp_clk) begin
                failures++;
                $display("FAIL random M=%0d: pulse=%b clk=%b required %b %b", bus.max_counter_value, bus.out_pulse, bus.out_clk, exp_pulse, exp_clk);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.max_counter_value = 10;
        @(negedge sys_clk);
        test_reset();
        test_duty();
        test_sweep();
        test_m_zero_one();
        test_reduce();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
